// File: rtl/fu_sequencer_if.sv
// Instruction and result handshake bundle between the control path and fu_sequencer.
// The sequencer uses the slave view; the issuing control path uses the master view.
interface fu_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              instr_valid;
   logic              instr_ready;
   logic [12:0]       instr;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [3:0]        res_flags;

   modport slave (
      input  instr_valid, instr, res_ready,
      output instr_ready, res_valid, res_data, res_flags
   );

   modport master (
      output instr_valid, instr, res_ready,
      input  instr_ready, res_valid, res_data, res_flags
   );
endinterface

// File: rtl/fu_sequencer.sv
// Function-unit sequencer: owns an 8-entry register file, issues {fs, rd, ra, rb}
// to an external combinational function unit and returns F/flags over a valid/ready port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | ready for an instruction; register-file loads honoured
//   S_ISSUE | operands on fu_a/fu_b/fu_fs; result and flags captured at edge
//   S_DONE  | res_valid high, result held until res_ready is sampled
module fu_sequencer #(
   parameter int DATA_W = 8,
   parameter int NREG   = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   fu_sequencer_if.slave     bus,
   input  logic              ld_en,
   input  logic [2:0]        ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] fu_a,
   output logic [DATA_W-1:0] fu_b,
   output logic [3:0]        fu_fs,
   input  logic [DATA_W-1:0] fu_f,
   input  logic              fu_v,
   input  logic              fu_c,
   input  logic              fu_n,
   input  logic              fu_z,
   output logic [CNT_W-1:0]  op_count,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [2:0]        rd_q, rd_d;
   logic [DATA_W-1:0] fu_a_q, fu_a_d;
   logic [DATA_W-1:0] fu_b_q, fu_b_d;
   logic [3:0]        fu_fs_q, fu_fs_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic [3:0]        res_flags_q, res_flags_d;
   logic              res_valid_q, res_valid_d;
   logic              instr_ready_q, instr_ready_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic [3:0] in_fs;
   logic [2:0] in_rd;
   logic [2:0] in_ra;
   logic [2:0] in_rb;

   assign in_fs = bus.instr[12:9];
   assign in_rd = bus.instr[8:6];
   assign in_ra = bus.instr[5:3];
   assign in_rb = bus.instr[2:0];

   always_comb begin
      state_d       = state_q;
      rf_d          = rf_q;
      rd_d          = rd_q;
      fu_a_d        = fu_a_q;
      fu_b_d        = fu_b_q;
      fu_fs_d       = fu_fs_q;
      res_data_d    = res_data_q;
      res_flags_d   = res_flags_q;
      res_valid_d   = res_valid_q;
      op_count_d    = op_count_q;

      unique case (state_q)
         S_IDLE: begin
            // Operands read rf_q, so a same-edge load to ra/rb is not forwarded.
            if (ld_en) begin
               rf_d[ld_addr] = ld_data;
            end
            if (bus.instr_valid) begin
               fu_a_d  = rf_q[in_ra];
               fu_b_d  = rf_q[in_rb];
               fu_fs_d = in_fs;
               rd_d    = in_rd;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            res_data_d  = fu_f;
            res_flags_d = {fu_v, fu_c, fu_n, fu_z};
            rf_d[rd_q]  = fu_f;
            op_count_d  = op_count_q + CNT_W'(1);
            res_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase

      instr_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         rd_q          <= '0;
         fu_a_q        <= '0;
         fu_b_q        <= '0;
         fu_fs_q       <= '0;
         res_data_q    <= '0;
         res_flags_q   <= '0;
         res_valid_q   <= 1'b0;
         instr_ready_q <= 1'b1;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         rf_q          <= rf_d;
         rd_q          <= rd_d;
         fu_a_q        <= fu_a_d;
         fu_b_q        <= fu_b_d;
         fu_fs_q       <= fu_fs_d;
         res_data_q    <= res_data_d;
         res_flags_q   <= res_flags_d;
         res_valid_q   <= res_valid_d;
         instr_ready_q <= instr_ready_d;
         op_count_q    <= op_count_d;
      end
   end

   assign bus.instr_ready = instr_ready_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_flags   = res_flags_q;
   assign fu_a            = fu_a_q;
   assign fu_b            = fu_b_q;
   assign fu_fs           = fu_fs_q;
   assign op_count        = op_count_q;
   assign dbg_data        = rf_q[dbg_addr];

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer, closing the loop through a behavioural function-unit model.
module tb_fu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       ld_en;
   logic [2:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] fu_a, fu_b;
   logic [3:0] fu_fs;
   logic [7:0] fu_f;
   logic       fu_v, fu_c, fu_n, fu_z;
   logic [15:0] op_count;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   int n_vec = 0;
   int n_err = 0;

   fu_sequencer_if bus ();

   fu_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .fu_a     (fu_a),
      .fu_b     (fu_b),
      .fu_fs    (fu_fs),
      .fu_f     (fu_f),
      .fu_v     (fu_v),
      .fu_c     (fu_c),
      .fu_n     (fu_n),
      .fu_z     (fu_z),
      .op_count (op_count),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural function unit: arithmetic is A + B' + cin with carry/overflow.
   logic [7:0] m_bb;
   logic       m_cin;
   logic [8:0] m_sum;
   always_comb begin
      m_bb  = 8'h00;
      m_cin = 1'b0;
      m_sum = 9'h000;
      fu_f  = 8'h00;
      fu_v  = 1'b0;
      fu_c  = 1'b0;
      if (fu_fs[3]) begin
         case (fu_fs[1:0])
            2'b00:   fu_f = fu_a & fu_b;
            2'b01:   fu_f = fu_a | fu_b;
            2'b10:   fu_f = fu_a ^ fu_b;
            default: fu_f = ~fu_a;
         endcase
      end else begin
         case (fu_fs[2:0])
            3'd1:    begin m_bb = 8'h00; m_cin = 1'b1; end
            3'd2:    begin m_bb = fu_b;  m_cin = 1'b0; end
            3'd3:    begin m_bb = fu_b;  m_cin = 1'b1; end
            3'd4:    begin m_bb = ~fu_b; m_cin = 1'b0; end
            3'd5:    begin m_bb = ~fu_b; m_cin = 1'b1; end
            3'd6:    begin m_bb = 8'hFF; m_cin = 1'b0; end
            default: begin m_bb = 8'h00; m_cin = 1'b0; end
         endcase
         m_sum = {1'b0, fu_a} + {1'b0, m_bb} + {8'h00, m_cin};
         fu_f  = m_sum[7:0];
         fu_c  = m_sum[8];
         fu_v  = (fu_a[7] == m_bb[7]) && (fu_f[7] != fu_a[7]);
      end
      fu_n = fu_f[7];
      fu_z = (fu_f == 8'h00);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dbg_chk(input string tag, input logic [2:0] a, input logic [7:0] e);
      dbg_addr = a;
      #1;
      check(tag, {8'h00, dbg_data}, {8'h00, e});
   endtask

   task automatic load(input logic [2:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_en   = 1'b0;
   endtask

   // Presents one instruction for the accept edge; returns at the negedge in ISSUE.
   task automatic offer(input logic [3:0] fs, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb);
      bus.instr_valid = 1'b1;
      bus.instr       = {fs, rd, ra, rb};
      tick();
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      ld_en           = 1'b0;
      ld_addr         = 3'd0;
      ld_data         = 8'h00;
      dbg_addr        = 3'd0;
      bus.instr_valid = 1'b0;
      bus.instr       = 13'h0000;
      bus.res_ready   = 1'b0;
      @(negedge clk);
      tick();
      tick();

      check("rst_res_valid",   {15'h0, bus.res_valid},   16'h0000);
      check("rst_instr_ready", {15'h0, bus.instr_ready}, 16'h0001);
      check("rst_op_count",    op_count,                 16'h0000);
      check("rst_fu_a",        {8'h00, fu_a},            16'h0000);
      for (int i = 0; i < 8; i++) begin
         dbg_chk("rst_rf", 3'(i), 8'h00);
      end
      rst_n = 1'b1;

      load(3'd1, 8'h35);
      load(3'd2, 8'h0F);
      dbg_chk("load_r1", 3'd1, 8'h35);
      bus.res_ready = 1'b1;

      // add r3 = r1 + r2
      offer(4'b0010, 3'd3, 3'd1, 3'd2);
      check("add_fu_a",        {8'h00, fu_a},            16'h0035);
      check("add_fu_b",        {8'h00, fu_b},            16'h000F);
      check("add_fu_fs",       {12'h000, fu_fs},         16'h0002);
      check("issue_ready",     {15'h0, bus.instr_ready}, 16'h0000);
      check("issue_valid",     {15'h0, bus.res_valid},   16'h0000);
      tick();
      check("add_valid",       {15'h0, bus.res_valid},   16'h0001);
      check("add_data",        {8'h00, bus.res_data},    16'h0044);
      check("add_flags",       {12'h000, bus.res_flags}, 16'h0000);
      tick();
      check("add_valid_drop",  {15'h0, bus.res_valid},   16'h0000);
      check("add_ready_back",  {15'h0, bus.instr_ready}, 16'h0001);
      dbg_chk("add_wb_r3", 3'd3, 8'h44);
      check("add_count",       op_count,                 16'h0001);

      // sub then AND back-to-back at 3 cycles per op
      offer(4'b0101, 3'd4, 3'd1, 3'd2);
      tick();
      check("sub_data",        {8'h00, bus.res_data},    16'h0026);
      check("sub_flags",       {12'h000, bus.res_flags}, 16'h0004);
      tick();
      offer(4'b1000, 3'd5, 3'd4, 3'd2);
      check("and_fu_a_wb",     {8'h00, fu_a},            16'h0026);
      tick();
      check("and_data",        {8'h00, bus.res_data},    16'h0006);
      check("and_flags",       {12'h000, bus.res_flags}, 16'h0000);
      tick();
      check("b2b_count",       op_count,                 16'h0003);
      dbg_chk("and_wb_r5", 3'd5, 8'h06);

      // backpressure: A+B+1 held in DONE while instr_valid/ld_en are offered
      bus.res_ready = 1'b0;
      offer(4'b0011, 3'd6, 3'd1, 3'd2);
      tick();
      bus.instr_valid = 1'b1;
      bus.instr       = {4'b1100, 3'd6, 3'd2, 3'd2};
      ld_en           = 1'b1;
      ld_addr         = 3'd6;
      ld_data         = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",     {15'h0, bus.res_valid},   16'h0001);
         check("bp_data",      {8'h00, bus.res_data},    16'h0045);
         check("bp_ready",     {15'h0, bus.instr_ready}, 16'h0000);
         check("bp_fu_fs",     {12'h000, fu_fs},         16'h0003);
         tick();
      end
      bus.instr_valid = 1'b0;
      ld_en           = 1'b0;
      bus.res_ready   = 1'b1;
      tick();
      check("bp_release",      {15'h0, bus.res_valid},   16'h0000);
      dbg_chk("bp_wb_r6", 3'd6, 8'h45);
      check("bp_count",        op_count,                 16'h0004);

      // load collision on ra/rb at the accept edge, then loads in ISSUE/DONE
      ld_en   = 1'b1;
      ld_addr = 3'd1;
      ld_data = 8'hAA;
      offer(4'b0000, 3'd7, 3'd1, 3'd1);
      ld_addr = 3'd2;
      ld_data = 8'h77;
      check("coll_fu_a_old",   {8'h00, fu_a},            16'h0035);
      check("coll_fu_b_old",   {8'h00, fu_b},            16'h0035);
      tick();
      check("coll_data",       {8'h00, bus.res_data},    16'h0035);
      tick();
      ld_en = 1'b0;
      dbg_chk("coll_r1_new", 3'd1, 8'hAA);
      dbg_chk("coll_r2_kept", 3'd2, 8'h0F);
      dbg_chk("coll_wb_r7", 3'd7, 8'h35);
      check("coll_count",      op_count,                 16'h0005);

      // reset asserted while in ISSUE
      offer(4'b0010, 3'd0, 3'd1, 3'd2);
      rst_n = 1'b0;
      tick();
      check("mrst_valid",      {15'h0, bus.res_valid},   16'h0000);
      check("mrst_ready",      {15'h0, bus.instr_ready}, 16'h0001);
      check("mrst_count",      op_count,                 16'h0000);
      dbg_chk("mrst_r0", 3'd0, 8'h00);
      dbg_chk("mrst_r1", 3'd1, 8'h00);
      rst_n = 1'b1;
      tick();
      check("mrst_stay_idle",  {15'h0, bus.res_valid},   16'h0000);

      // carry/overflow/zero boundary, NOT, and A-1 after recovery
      load(3'd1, 8'h80);
      load(3'd2, 8'h80);
      offer(4'b0010, 3'd3, 3'd1, 3'd2);
      tick();
      check("ovf_data",        {8'h00, bus.res_data},    16'h0000);
      check("ovf_flags",       {12'h000, bus.res_flags}, 16'h000D);
      tick();
      offer(4'b1011, 3'd4, 3'd1, 3'd2);
      tick();
      check("not_data",        {8'h00, bus.res_data},    16'h007F);
      check("not_flags",       {12'h000, bus.res_flags}, 16'h0000);
      tick();
      offer(4'b0110, 3'd5, 3'd2, 3'd2);
      tick();
      check("dec_data",        {8'h00, bus.res_data},    16'h007F);
      check("dec_flags",       {12'h000, bus.res_flags}, 16'h000C);
      tick();
      check("post_count",      op_count,                 16'h0003);
      dbg_chk("post_r4", 3'd4, 8'h7F);
      dbg_chk("post_r3", 3'd3, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
